// File: rtl/ieee_sd_arbiter.sv
// Purpose: round-robin arbiter merging NBD block-device request channels onto one hps_io channel.
// Latency: grant and sd_rd/sd_wr registered one edge after a request is sampled; dev_ack/sd_buff_din combinational.
// Backpressure: a granted request is held until sd_ack; other devices wait, levels stay pending for later grants.
//
// Ports:
//   clk_sys, reset            - system clock, synchronous active-high reset
//   dev_lba/blk_cnt/rd/wr     - per-device request channel (arrays indexed by device)
//   dev_ack, dev_buff_din     - per-device ack (owner only) and write data
//   sd_lba/blk_cnt/rd/wr      - merged request towards hps_io
//   sd_ack, sd_buff_din       - ack from hps_io, write data of the owning device
//   busy                      - high whenever a transfer is in progress (state != IDLE)
module ieee_sd_arbiter #(
    parameter int NBD = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [31:0] dev_lba      [NBD],
    input  logic [5:0]  dev_blk_cnt  [NBD],
    input  logic [NBD-1:0] dev_rd,
    input  logic [NBD-1:0] dev_wr,
    output logic [NBD-1:0] dev_ack,
    input  logic [7:0]  dev_buff_din [NBD],
    output logic [31:0] sd_lba,
    output logic [5:0]  sd_blk_cnt,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    output logic [7:0]  sd_buff_din,
    output logic        busy
);

    localparam int OW = (NBD > 1) ? $clog2(NBD) : 1;

    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

    state_t        state, state_nxt;
    logic [OW-1:0] owner, owner_nxt;
    logic [OW-1:0] last_owner, last_owner_nxt;
    logic [31:0]   lba_nxt;
    logic [5:0]    blk_cnt_nxt;
    logic          rd_nxt, wr_nxt;

    logic [NBD-1:0] req;
    logic           found;
    logic [OW-1:0]  pick;

    assign req = dev_rd | dev_wr;

    // First requesting index after the previous owner, wrapping around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NBD; k++) begin
            int idx;
            idx = (int'(last_owner) + k) % NBD;
            if (!found && req[idx]) begin
                pick  = OW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        lba_nxt        = sd_lba;
        blk_cnt_nxt    = sd_blk_cnt;
        rd_nxt         = sd_rd;
        wr_nxt         = sd_wr;
        case (state)
            IDLE: begin
                // A still-high ack from an earlier transfer must drain before a new grant.
                if (found && !sd_ack) begin
                    state_nxt      = REQ;
                    owner_nxt      = pick;
                    last_owner_nxt = pick;
                    lba_nxt        = dev_lba[pick];
                    blk_cnt_nxt    = dev_blk_cnt[pick];
                    // Write wins a simultaneous read; the read level stays for a later grant.
                    wr_nxt         = dev_wr[pick];
                    rd_nxt         = ~dev_wr[pick];
                end
            end
            REQ: begin
                // hps_io cannot cancel, so the request is held even if the device withdraws.
                if (sd_ack) begin
                    state_nxt = XFER;
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                end
            end
            XFER: begin
                if (!sd_ack) state_nxt = GAP;
            end
            GAP: begin
                // Guarantees the device observes dev_ack low before any re-grant.
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(NBD - 1);
            sd_lba     <= '0;
            sd_blk_cnt <= '0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            sd_lba     <= lba_nxt;
            sd_blk_cnt <= blk_cnt_nxt;
            sd_rd      <= rd_nxt;
            sd_wr      <= wr_nxt;
        end
    end

    logic active;
    assign active = (state == REQ) || (state == XFER);
    assign busy   = (state != IDLE);

    // Ack and write data are routed to/from the owner only while it holds the channel.
    always_comb begin
        dev_ack = '0;
        for (int i = 0; i < NBD; i++) begin
            dev_ack[i] = sd_ack && active && (owner == OW'(i));
        end
    end

    assign sd_buff_din = active ? dev_buff_din[owner] : 8'h00;

endmodule

// File: tb/tb_ieee_sd_arbiter.sv
module tb_ieee_sd_arbiter;

    localparam int NBD = 4;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] dev_lba      [NBD];
    logic [5:0]  dev_blk_cnt  [NBD];
    logic [NBD-1:0] dev_rd, dev_wr, dev_ack;
    logic [7:0]  dev_buff_din [NBD];
    logic [31:0] sd_lba;
    logic [5:0]  sd_blk_cnt;
    logic        sd_rd, sd_wr, sd_ack, busy;
    logic [7:0]  sd_buff_din;

    int n_tests = 0;
    int n_fail  = 0;

    ieee_sd_arbiter #(.NBD(NBD)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .dev_lba      (dev_lba),
        .dev_blk_cnt  (dev_blk_cnt),
        .dev_rd       (dev_rd),
        .dev_wr       (dev_wr),
        .dev_ack      (dev_ack),
        .dev_buff_din (dev_buff_din),
        .sd_lba       (sd_lba),
        .sd_blk_cnt   (sd_blk_cnt),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_din  (sd_buff_din),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        dev_rd = '0;
        dev_wr = '0;
        sd_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Waits (bounded) for a request, checks it against the expected device/op, then acks it.
    task automatic serve(input int exp_dev, input logic exp_wr, input int ack_cycles);
        logic [NBD-1:0] oh;
        for (int c = 0; c < 40 && !(sd_rd || sd_wr); c++) tick();
        if (!(sd_rd || sd_wr)) begin
            chk("req_timeout", 1'b0, 1'b1);
            return;
        end
        chk("op_wr", sd_wr, exp_wr);
        chk("op_rd", sd_rd, !exp_wr);
        chk("grant_lba", sd_lba, 64'h100 + 64'(exp_dev));
        chk("grant_cnt", sd_blk_cnt, 64'(exp_dev + 1));
        sd_ack = 1'b1;
        #1;
        oh = '0;
        oh[exp_dev] = 1'b1;
        chk("ack_route", dev_ack, oh);
        chk("wdata_route", sd_buff_din, 64'hA0 + 64'(exp_dev));
        for (int c = 0; c < ack_cycles; c++) tick();
        chk("req_released", {sd_rd, sd_wr}, 2'b00);
        sd_ack = 1'b0;
        #1;
        chk("ack_drop", dev_ack, '0);
    endtask

    initial begin
        for (int i = 0; i < NBD; i++) begin
            dev_lba[i]      = 32'h100 + i;
            dev_blk_cnt[i]  = 6'(i + 1);
            dev_buff_din[i] = 8'hA0 + 8'(i);
        end

        // Reset values
        do_reset();
        chk("rst_sd_rd", sd_rd, 1'b0);
        chk("rst_sd_wr", sd_wr, 1'b0);
        chk("rst_lba", sd_lba, 32'h0);
        chk("rst_cnt", sd_blk_cnt, 6'h0);
        chk("rst_ack", dev_ack, '0);
        chk("rst_wdata", sd_buff_din, 8'h00);
        chk("rst_busy", busy, 1'b0);

        // Single read on device 1
        dev_lba[1]     = 32'h0000_1234;
        dev_blk_cnt[1] = 6'd0;
        dev_rd[1]      = 1'b1;
        #1;
        chk("sr_not_yet", sd_rd, 1'b0);
        tick();
        chk("sr_rd", sd_rd, 1'b1);
        chk("sr_lba", sd_lba, 32'h1234);
        chk("sr_cnt", sd_blk_cnt, 6'd0);
        chk("sr_busy", busy, 1'b1);
        chk("sr_noack", dev_ack, '0);
        dev_rd[1]      = 1'b0;
        dev_lba[1]     = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("sr_hold", sd_rd, 1'b1);
        sd_ack = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("sr_ack_win", dev_ack, 4'b0010);
            tick();
            chk("sr_released", sd_rd, 1'b0);
        end
        sd_ack = 1'b0;
        #1;
        chk("sr_ack_off", dev_ack, '0);
        tick();
        chk("sr_gap_busy", busy, 1'b1);
        tick();
        chk("sr_idle", busy, 1'b0);
        chk("sr_lba_stable", sd_lba, 32'h1234);
        dev_lba[1]     = 32'h101;
        dev_blk_cnt[1] = 6'd2;

        // Round-robin with all devices requesting
        do_reset();
        dev_rd = 4'b1111;
        serve(0, 1'b0, 2);
        serve(1, 1'b0, 1);
        serve(2, 1'b0, 3);
        serve(3, 1'b0, 1);
        serve(0, 1'b0, 1);
        dev_rd = '0;
        tick(); tick(); tick();

        // Read/write collision on device 0: write first, read on next grant
        do_reset();
        dev_rd[0] = 1'b1;
        dev_wr[0] = 1'b1;
        serve(0, 1'b1, 1);
        dev_wr[0] = 1'b0;
        serve(0, 1'b0, 1);
        dev_rd[0] = 1'b0;
        tick(); tick(); tick();
        chk("col_idle", busy, 1'b0);

        // Withdrawn request: device 1 pulses its read for one cycle
        dev_rd[1] = 1'b1;
        tick();
        chk("wd_rd", sd_rd, 1'b1);
        dev_rd[1] = 1'b0;
        tick(); tick(); tick();
        chk("wd_hold", sd_rd, 1'b1);
        sd_ack = 1'b1;
        #1;
        chk("wd_ack", dev_ack, 4'b0010);
        tick();
        sd_ack = 1'b0;
        tick(); tick();
        chk("wd_idle", busy, 1'b0);
        chk("wd_rd_low", sd_rd, 1'b0);

        // Reset during XFER, then a stuck ack blocks any new grant
        dev_rd[2] = 1'b1;
        tick();
        sd_ack = 1'b1;
        tick();
        chk("rx_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rx_busy0", busy, 1'b0);
        chk("rx_rd0", sd_rd, 1'b0);
        chk("rx_ack0", dev_ack, '0);
        chk("rx_lba0", sd_lba, 32'h0);
        chk("rx_wdata0", sd_buff_din, 8'h00);
        tick(); tick(); tick();
        chk("sp_nogrant", {busy, sd_rd}, 2'b00);
        chk("sp_noack", dev_ack, '0);
        sd_ack = 1'b0;
        tick();
        chk("sp_grant", sd_rd, 1'b1);
        chk("sp_lba", sd_lba, 32'h102);
        dev_rd[2] = 1'b0;
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        tick(); tick(); tick();
        chk("end_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ieee_sd_arbiter.md
# ieee_sd_arbiter

Merges the per-subunit block-device request channels of the IEEE drive bank (NBD = drives × subunits) onto the single MiSTer hps_io block-device channel. Sits directly downstream of the drive bank's sd_lba/sd_blk_cnt/sd_rd/sd_wr/sd_buff_din outputs and upstream of hps_io. It grants one device at a time with round-robin fairness, holds the request handshake, and routes sd_ack and write data for the owning device only.

## Interface
Parameters:
- NBD, 2: number of block devices arbitrated (1..8)

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- dev_lba  in  32×NBD  per-device LBA (unpacked array)
- dev_blk_cnt  in  6×NBD  per-device block count minus one (unpacked array)
- dev_rd  in  NBD  per-device read request, level
- dev_wr  in  NBD  per-device write request, level
- dev_ack  out  NBD  per-device ack, one-hot or zero
- dev_buff_din  in  8×NBD  per-device write data (unpacked array)
- sd_lba  out  32  LBA to hps_io
- sd_blk_cnt  out  6  block count to hps_io
- sd_rd  out  1  read request to hps_io
- sd_wr  out  1  write request to hps_io
- sd_ack  in  1  ack from hps_io
- sd_buff_din  out  8  write data to hps_io
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, REQ, XFER, GAP.
- IDLE: requests are sampled as req[i] = dev_rd[i] | dev_wr[i]. If any are set, grant the first set index starting at (last_owner+1) mod NBD, wrapping. Register the grant in owner, set last_owner = owner, latch dev_lba[owner] to sd_lba, latch dev_blk_cnt[owner] to sd_blk_cnt, and latch the operation. Go to REQ.
- Operation: write if dev_wr[owner] is set, else read. If both are set, write wins. The read stays pending for a later grant.
- REQ: assert sd_rd or sd_wr per the latched operation. Stay in REQ until sd_ack = 1. On the first cycle sd_ack = 1, go to XFER.
- XFER: sd_rd and sd_wr are low. Stay in XFER while sd_ack = 1. When sd_ack = 0, go to GAP.
- GAP: one idle cycle, then go to IDLE. This guarantees the device sees dev_ack low before any re-grant.
- dev_ack[i] = sd_ack & (state ∈ {REQ, XFER}) & (owner == i). This is combinational with zero latency. All other bits are 0.
- sd_buff_din = dev_buff_din[owner] in REQ and XFER, and 0 otherwise. This is combinational.
- sd_lba and sd_blk_cnt stay stable from the grant cycle until the next grant. Device changes to its inputs after the grant are ignored.
- Request withdrawn in REQ before ack: hps_io cannot cancel, so the request stays asserted and the transfer completes. The owner receives the ack and ignores it.
- sd_ack high in IDLE or GAP (spurious) is ignored and no dev_ack is raised. An IDLE grant is blocked while sd_ack = 1.
- NBD = 1: the grant is always index 0. Round-robin logic degenerates.

## Timing
- Reset values: state = IDLE, owner = 0, last_owner = NBD−1 (so device 0 is served first), sd_rd = sd_wr = 0, sd_lba = 0, sd_blk_cnt = 0, dev_ack = 0, sd_buff_din = 0, busy = 0.
- Reset mid-transfer: next cycle is IDLE with all outputs at reset values. Any late sd_ack is ignored per the spurious rule.
- Request latency: request visible at edge N in IDLE → sd_rd/sd_wr high after edge N+1.
- Release: sd_ack high at edge M in REQ → sd_rd/sd_wr low after edge M+1.
- Turnaround: sd_ack low at edge K in XFER → GAP after K+1 → IDLE after K+2 → earliest next sd_rd after K+3.
- All FSM outputs are registered except dev_ack and sd_buff_din.

## Test plan
- Single read: dev_rd[1] = 1, dev_lba[1] = 0x0000_1234, dev_blk_cnt[1] = 0; hps acks 3 cycles later for 10 cycles → sd_rd high 1 cycle after request, sd_lba = 0x1234, sd_blk_cnt = 0, dev_ack = 2'b10 for exactly the ack window, sd_rd drops 1 cycle after ack rises.
- Round-robin: NBD = 4, dev_rd = 4'b1111 held through completions → grants in order 0, 1, 2, 3, 0. No device is granted twice before the others.
- Read/write collision: dev_rd[0] = dev_wr[0] = 1 → sd_wr asserted first, then sd_rd on the next grant. sd_buff_din equals dev_buff_din[0] during the write ack.
- Withdrawn request: dev_rd[1] pulses 1 cycle → sd_rd stays high until ack. dev_ack[1] follows sd_ack. Back to IDLE with sd_rd = 0.
- Reset and spurious ack: reset asserted during XFER → next cycle all outputs 0, state IDLE. sd_ack held high with no request → dev_ack = 0 and no grant until sd_ack falls.
